// File: rtl/diff_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package diff_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default datapath width, kept identical to the combinational adder.
  localparam int BUS_WIDTH = 8;

endpackage

// File: rtl/diff_serial_sub_bit.sv
// Single-bit full subtractor: d = a - b - bin, bout set when the result underflows.
module sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/diff_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell reused LSB first over WIDTH cycles.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and out_valid holds until out_ready.
module diff_serial
  import diff_serial_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output state_t           dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, out_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, borrow_q;

  logic             bit_d, brw_d;
  logic [WIDTH-1:0] r_d;

  sub_bit u_sub_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q),
    .d    (bit_d),
    .bout (brw_d)
  );

  assign r_d = {bit_d, r_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in1;
            b_q     <= in2;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          r_q   <= r_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          brw_q <= brw_d;
          // Counter parks at its last value so it never wraps within an operation.
          if (cnt_q == CNT_LAST) begin
            out_q    <= r_d;
            borrow_q <= brw_d;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign borrow      = borrow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_diff_serial.sv
// Directed and randomised checks for diff_serial at the default 8-bit width.
module tb_diff_serial;
  import diff_serial_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1, in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         borrow;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W:0] exp_q[$];

  diff_serial #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .borrow      (borrow),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: present operands until accepted; returns after the accepting edge (+1).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    while (!in_ready && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in1 = a;
    in2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for a result, optionally stall gap cycles, then take it.
  task automatic recv(input int gap, output logic [W-1:0] o, output logic bo, output int lat);
    lat = 0;
    if (gap == 0) out_ready = 1'b1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_wait", out_valid, 1);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    o = out;
    bo = borrow;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bw;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [W-1:0] o;
    logic         bo;
    int           lat;
    logic [W:0]   e;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_borrow", borrow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with latency check
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b);
      check("busy_in_ready", in_ready, 0);
      check("busy_state", 32'(dbg_state), 32'(RUN));
      recv(1, o, bo, lat);
      check("latency", lat, W);
      check("dir_out", o, vecs[i].d);
      check("dir_borrow", bo, vecs[i].bw);
      check("release_valid", out_valid, 0);
    end

    // Backpressure with ignored input activity
    send(8'hA5, 8'h5A);
    recv_wait: begin
      lat = 0;
      while (!out_valid && lat < 64) begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("bp_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in1 = 8'h33;
      in2 = 8'h44;
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_out", out, 8'h4B);
      check("bp_hold_borrow", borrow, 0);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", in_ready, 1);
    check("bp_out_kept", out, 8'h4B);

    // Simultaneous out_ready and in_valid in DONE: accept only in the next IDLE cycle
    send(8'h11, 8'h22);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("sim_first_out", out, 8'hEF);
    check("sim_first_borrow", borrow, 1);
    in_valid = 1'b1;
    in1 = 8'h3C;
    in2 = 8'hC3;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("sim_not_taken", in_ready, 1);
    check("sim_valid_low", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sim_taken", in_ready, 0);
    recv(0, o, bo, lat);
    check("sim_out", o, 8'h79);
    check("sim_borrow", bo, 1);

    // Reset in the middle of RUN
    send(8'hC8, 8'h21);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out", out, 0);
    check("mid_rst_borrow", borrow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h10, 8'h01);
    recv(2, o, bo, lat);
    check("post_rst_latency", lat, W);
    check("post_rst_out", o, 8'h0F);
    check("post_rst_borrow", bo, 0);

    // Randomised back-to-back with random consumer gaps
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      exp_q.push_back({(ra < rb), W'(ra - rb)});
      send(ra, rb);
      recv($urandom_range(0, 3), o, bo, lat);
      e = exp_q.pop_front();
      check("rand_result", {bo, o}, e);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
